// File: rtl/seq_pattern_detector_if.sv
// rtl/seq_pattern_detector_if.sv - sample, pattern-load and match signals of seq_pattern_detector
interface seq_pattern_detector_if #(
  parameter int PAT_W = 10,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_val;
  logic [LEN_W-1:0] pat_len;
  logic             load_err;
  logic             Z;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, x, overlap, pat_load, pat_val, pat_len,
    input  load_err, Z, match_cnt
  );

  modport slave (
    input  en, x, overlap, pat_load, pat_val, pat_len,
    output load_err, Z, match_cnt
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector with registered match pulse
// Defining SEQ_DET_MATCH_CNT_EN builds the saturating match counter; otherwise match_cnt is tied to 0.
module seq_pattern_detector #(
  parameter int             PAT_W   = 10,
  parameter int             LEN_W   = 4,
  parameter int             CNT_W   = 8,
  parameter int             DEF_LEN = 9,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(10'b0011011011)
) (
  input logic                  CLK,
  input logic                  RST,
  seq_pattern_detector_if.slave bus
);
  typedef enum logic {UNCFG, HUNT} state_t;

  localparam bit               DEF_OK   = (DEF_LEN >= 1) && (DEF_LEN <= PAT_W);
  localparam logic [LEN_W:0]   PAT_W_LX = (LEN_W+1)'(PAT_W);
  localparam logic [LEN_W-1:0] PAT_W_L  = LEN_W'(PAT_W);

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [PAT_W-2:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic             z_q;
  logic             load_err_q;

  logic [PAT_W-1:0] hist_d;
  logic [LEN_W-1:0] fill_d;
  logic [PAT_W-1:0] mask;
  logic             load_ok;
  logic             match;

  // Only the newest PAT_W-1 bits are stored; the incoming bit completes the window.
  always_comb begin
    hist_d  = {hist_q, bus.x};
    fill_d  = (fill_q == PAT_W_L) ? fill_q : fill_q + LEN_W'(1);
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    match   = (fill_d >= len_q) && ((hist_d & mask) == (pat_q & mask));
    load_ok = (bus.pat_len != '0) && ({1'b0, bus.pat_len} <= PAT_W_LX);
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= DEF_OK ? HUNT : UNCFG;
      pat_q      <= DEF_PAT;
      len_q      <= LEN_W'(DEF_LEN);
      hist_q     <= '0;
      fill_q     <= '0;
      z_q        <= 1'b0;
      load_err_q <= 1'b0;
`ifdef SEQ_DET_MATCH_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      z_q        <= 1'b0;
      load_err_q <= 1'b0;
      // A load wins over a coincident sample, which is dropped.
      if (bus.pat_load) begin
        if (load_ok) begin
          state_q <= HUNT;
          pat_q   <= bus.pat_val;
          len_q   <= bus.pat_len;
          hist_q  <= '0;
          fill_q  <= '0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (state_q == HUNT && bus.en) begin
        hist_q <= hist_d[PAT_W-2:0];
        fill_q <= (match && !bus.overlap) ? '0 : fill_d;
        if (match) begin
          z_q <= 1'b1;
`ifdef SEQ_DET_MATCH_CNT_EN
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
`endif
        end
      end
    end
  end

  assign bus.Z        = z_q;
  assign bus.load_err = load_err_q;
`ifdef SEQ_DET_MATCH_CNT_EN
  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   failures = 0;

  seq_pattern_detector_if #(.PAT_W(10), .LEN_W(4), .CNT_W(8)) bus ();
  seq_pattern_detector_if #(.PAT_W(10), .LEN_W(4), .CNT_W(2)) bus2 ();

  seq_pattern_detector #(.PAT_W(10), .LEN_W(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave)
  );
  seq_pattern_detector #(.PAT_W(10), .LEN_W(4), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .bus(bus2.slave)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample(input logic b);
    bus.en = 1'b1;
    bus.x  = b;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic do_reset();
    bus.en = 0; bus.x = 0; bus.overlap = 0; bus.pat_load = 0; bus.pat_val = '0; bus.pat_len = '0;
    bus2.en = 0; bus2.x = 0; bus2.overlap = 0; bus2.pat_load = 0; bus2.pat_val = '0; bus2.pat_len = '0;
    #3 RST = 1'b0;
    #4 RST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.Z !== 1'b0) begin failures++; $display("FAIL reset_z: got %b want 0", bus.Z); end
    checks++;
    if (bus.load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err: got %b want 0", bus.load_err); end
    checks++;
    if (bus.match_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", bus.match_cnt); end
  endtask

  task automatic test_basic();
    logic [8:0] s = 9'b011011011;
    do_reset();
    bus.overlap = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      sample(s[i]);
      checks++;
      if (bus.Z !== (i == 0)) begin
        failures++; $display("FAIL basic_z sample %0d: got %b want %b", 9 - i, bus.Z, (i == 0));
      end
    end
    tick();
    checks++;
    if (bus.Z !== 1'b0) begin failures++; $display("FAIL basic_z_clear: got %b want 0", bus.Z); end
    checks++;
    if (bus.match_cnt !== (CNT_ON ? 8'd1 : 8'd0)) begin
      failures++; $display("FAIL basic_cnt: got %0d want %0d", bus.match_cnt, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_overlap();
    logic [11:0] s = 12'b011011011011;
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      bus.overlap = m[0];
      for (int i = 11; i >= 0; i--) begin
        logic want;
        sample(s[i]);
        want = (i == 3) || (m == 1 && i == 0);
        checks++;
        if (bus.Z !== want) begin
          failures++; $display("FAIL overlap%0d_z sample %0d: got %b want %b", m, 12 - i, bus.Z, want);
        end
      end
      checks++;
      if (bus.match_cnt !== (CNT_ON ? 8'(m + 1) : 8'd0)) begin
        failures++; $display("FAIL overlap%0d_cnt: got %0d want %0d", m, bus.match_cnt, CNT_ON ? m + 1 : 0);
      end
    end
  endtask

  task automatic test_load_gaps();
    logic [4:0] s = 5'b10101;
    bus.overlap  = 1'b1;
    bus.pat_load = 1'b1; bus.pat_len = 4'd3; bus.pat_val = 10'b101;
    tick();
    bus.pat_load = 1'b0;
    checks++;
    if (bus.Z !== 1'b0 || bus.load_err !== 1'b0) begin
      failures++; $display("FAIL load3: got z=%b err=%b want 0 0", bus.Z, bus.load_err);
    end
    for (int i = 4; i >= 0; i--) begin
      sample(s[i]);
      checks++;
      if (bus.Z !== (i == 2 || i == 0)) begin
        failures++; $display("FAIL gaps_z sample %0d: got %b want %b", 5 - i, bus.Z, (i == 2 || i == 0));
      end
      bus.x = ~s[i];
      tick();
      checks++;
      if (bus.Z !== 1'b0) begin failures++; $display("FAIL gaps_idle_z after %0d: got %b want 0", 5 - i, bus.Z); end
    end
  endtask

  task automatic test_load_err();
    logic [3:0] bad [2] = '{4'd0, 4'd11};
    logic [2:0] s = 3'b101;
    for (int k = 0; k < 2; k++) begin
      bus.pat_load = 1'b1; bus.pat_len = bad[k]; bus.pat_val = 10'h3FF;
      tick();
      bus.pat_load = 1'b0;
      checks++;
      if (bus.load_err !== 1'b1) begin failures++; $display("FAIL load_err len %0d: got %b want 1", bad[k], bus.load_err); end
      tick();
      checks++;
      if (bus.load_err !== 1'b0) begin failures++; $display("FAIL load_err_clear len %0d: got %b want 0", bad[k], bus.load_err); end
    end
    for (int i = 2; i >= 0; i--) begin
      sample(s[i]);
      checks++;
      if (bus.Z !== (i == 0)) begin failures++; $display("FAIL old_pat_z sample %0d: got %b want %b", 3 - i, bus.Z, (i == 0)); end
    end
  endtask

  task automatic test_load_priority_and_reset();
    logic [8:0] s = 9'b011011011;
    do_reset();
    bus.overlap = 1'b0;
    for (int i = 8; i >= 1; i--) sample(s[i]);
    bus.pat_load = 1'b1; bus.pat_len = 4'd9; bus.pat_val = 10'b0011011011;
    bus.en = 1'b1; bus.x = 1'b1;
    tick();
    bus.pat_load = 1'b0; bus.en = 1'b0;
    checks++;
    if (bus.Z !== 1'b0) begin failures++; $display("FAIL load_with_en_z: got %b want 0", bus.Z); end
    for (int i = 8; i >= 0; i--) begin
      sample(s[i]);
      checks++;
      if (bus.Z !== (i == 0)) begin failures++; $display("FAIL after_load_z sample %0d: got %b want %b", 9 - i, bus.Z, (i == 0)); end
    end
    for (int i = 8; i >= 4; i--) sample(s[i]);
    #2 RST = 1'b0;
    #2 RST = 1'b1;
    checks++;
    if (bus.Z !== 1'b0) begin failures++; $display("FAIL mid_reset_z: got %b want 0", bus.Z); end
    for (int i = 8; i >= 0; i--) begin
      sample(s[i]);
      checks++;
      if (bus.Z !== (i == 0)) begin failures++; $display("FAIL post_reset_z sample %0d: got %b want %b", 9 - i, bus.Z, (i == 0)); end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    bus2.pat_load = 1'b1; bus2.pat_len = 4'd1; bus2.pat_val = 10'b1;
    tick();
    bus2.pat_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus2.en = 1'b1; bus2.x = 1'b1; bus2.overlap = i[0];
      tick();
      bus2.en = 1'b0;
      checks++;
      if (bus2.Z !== 1'b1) begin failures++; $display("FAIL len1_z sample %0d: got %b want 1", i + 1, bus2.Z); end
      checks++;
      if (bus2.match_cnt !== (CNT_ON ? exp_cnt[i] : 2'd0)) begin
        failures++; $display("FAIL sat_cnt sample %0d: got %0d want %0d", i + 1, bus2.match_cnt, CNT_ON ? exp_cnt[i] : 2'd0);
      end
    end
    bus2.en = 1'b1; bus2.x = 1'b0;
    tick();
    bus2.en = 1'b0;
    checks++;
    if (bus2.Z !== 1'b0) begin failures++; $display("FAIL len1_zero_z: got %b want 0", bus2.Z); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_load_gaps();
    test_load_err();
    test_load_priority_and_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
